// File: rtl/pipe_add_if.sv
// pipe_add_if: operand/result stream bundle for pipe_add.
//
// Operand side : in_valid, in_ready, a, b, cin, sub
// Result side  : out_valid, out_ready, sum, cout
//
// The modport named "slave" belongs to the adder. It consumes operand beats
// and produces result beats. The modport named "master" belongs to whatever
// drives operands and accepts results.
interface pipe_add_if #(
  parameter int WIDTH = 100
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipe_add.sv
// pipe_add: pipelined ripple-segment adder/subtractor on a valid/ready stream.
//
//   {cout, sum} = a + (sub ? ~b : b) + cin
//
// The operand word is cut into SEG-bit segments, and one segment is added per
// pipeline stage. The carry between stages is registered, so the longest path
// is a single SEG-bit ripple. STAGES = ceil(WIDTH/SEG). A beat accepted at a
// clock edge leaves the pipeline STAGES edges later, counting the capture edge.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset; clears every valid bit and the
//          visible sum/cout
//   s    - pipe_add_if.slave:
//          in_valid/in_ready/a/b/cin/sub    operand beat
//          out_valid/out_ready/sum/cout     result beat
//
// Flow control: the whole pipeline advances together unless the final stage
// holds a result the consumer refuses. in_ready is that advance signal, so it
// depends only on out_valid/out_ready, never on in_valid.
module pipe_add #(
  parameter int WIDTH = 100,
  parameter int SEG   = 25
) (
  input logic       clk,
  input logic       rst,
  pipe_add_if.slave s
);

  localparam int STAGES = (WIDTH + SEG - 1) / SEG;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign advance    = !(s.out_valid && !s.out_ready);
  assign s.in_ready = advance;

  // B is inverted once, at capture. Later stages only ever see B'.
  assign b_eff = s.sub ? ~s.b : s.b;

  // Stage k adds bits [HI:LO] and stores the finished low word [HI:0] and
  // its carry. It also stores whatever operand bits above HI are still
  // unsummed (REM of them). The last stage has none left to store.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int HI  = (LO + SEG > WIDTH) ? WIDTH - 1 : LO + SEG - 1;
    localparam int SW  = HI - LO + 1;
    localparam int REM = WIDTH - 1 - HI;

    logic          vld_in;
    logic          cy_in;
    logic [SW-1:0] seg_a;
    logic [SW-1:0] seg_b;
    logic [SW:0]   seg_sum;
    logic [HI:0]   acc_d;

    logic          vld_q;
    logic          cy_q;
    logic [HI:0]   acc_q;

    if (k == 0) begin : g_head
      assign vld_in = s.in_valid;
      assign cy_in  = s.cin;
      assign seg_a  = s.a[HI:0];
      assign seg_b  = b_eff[HI:0];
      assign acc_d  = seg_sum[SW-1:0];
    end else begin : g_body
      // Segment k occupies the low SW bits of the predecessor's leftover
      // operands. The finished low word is passed along unchanged.
      assign vld_in = g_stage[k-1].vld_q;
      assign cy_in  = g_stage[k-1].cy_q;
      assign seg_a  = g_stage[k-1].g_rest.opa_q[SW-1:0];
      assign seg_b  = g_stage[k-1].g_rest.opb_q[SW-1:0];
      assign acc_d  = {seg_sum[SW-1:0], g_stage[k-1].acc_q};
    end

    // One extra bit so the segment carry falls out of the add.
    assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SW{1'b0}}, cy_in};

    // NOTE: state is updated with non-blocking assignments so that every
    // stage samples its predecessor's value from before this clock edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        acc_q <= '0;
      end else if (advance) begin
        vld_q <= vld_in;
        cy_q  <= seg_sum[SW];
        acc_q <= acc_d;
      end
    end

    if (REM > 0) begin : g_rest
      logic [REM-1:0] opa_d;
      logic [REM-1:0] opb_d;
      logic [REM-1:0] opa_q;
      logic [REM-1:0] opb_q;

      if (k == 0) begin : g_cap
        assign opa_d = s.a[WIDTH-1:HI+1];
        assign opb_d = b_eff[WIDTH-1:HI+1];
      end else begin : g_fwd
        assign opa_d = g_stage[k-1].g_rest.opa_q[REM+SW-1:SW];
        assign opb_d = g_stage[k-1].g_rest.opb_q[REM+SW-1:SW];
      end

      // NOTE: the pending-operand registers have no reset. Their contents
      // matter only under a set valid bit, and reset clears every valid bit.
      always_ff @(posedge clk) begin
        if (advance) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end
  end

  // The final stage holds the whole aligned word.
  assign s.out_valid = g_stage[STAGES-1].vld_q;
  assign s.sum       = g_stage[STAGES-1].acc_q;
  assign s.cout      = g_stage[STAGES-1].cy_q;

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: self-checking bench for pipe_add.
//
// Four configurations run side by side on one clock and one reset:
//   w=0 : WIDTH=100, SEG=25  (4 stages)
//   w=1 : WIDTH=100, SEG=32  (4 stages, last segment 4 bits)
//   w=2 : WIDTH=8,   SEG=8   (1 stage)
//   w=3 : WIDTH=8,   SEG=1   (8 stages)
// Inputs are driven and outputs sampled around the falling edge.
module tb_pipe_add;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipe_add_if #(.WIDTH(100)) dif ();
  pipe_add_if #(.WIDTH(100)) sif ();
  pipe_add_if #(.WIDTH(8))   aif ();
  pipe_add_if #(.WIDTH(8))   bif ();

  pipe_add #(.WIDTH(100), .SEG(25)) u_def (.clk(clk), .rst(rst), .s(dif));
  pipe_add #(.WIDTH(100), .SEG(32)) u_s32 (.clk(clk), .rst(rst), .s(sif));
  pipe_add #(.WIDTH(8),   .SEG(8))  u_w8a (.clk(clk), .rst(rst), .s(aif));
  pipe_add #(.WIDTH(8),   .SEG(1))  u_w8b (.clk(clk), .rst(rst), .s(bif));

  always #5 clk = ~clk;

  // Reference: plain WIDTH+1-bit arithmetic for the 100-bit configurations.
  function automatic logic [100:0] ref_add(input logic [99:0] a, input logic [99:0] b,
                                           input logic ci, input logic su);
    logic [99:0] bb;
    bb = su ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {100'd0, ci};
  endfunction

  task automatic drive(input int w, input logic v, input logic [99:0] a,
                       input logic [99:0] b, input logic ci, input logic su);
    case (w)
      0: begin dif.in_valid = v; dif.a = a; dif.b = b; dif.cin = ci; dif.sub = su; end
      1: begin sif.in_valid = v; sif.a = a; sif.b = b; sif.cin = ci; sif.sub = su; end
      2: begin aif.in_valid = v; aif.a = a[7:0]; aif.b = b[7:0]; aif.cin = ci; aif.sub = su; end
      default: begin bif.in_valid = v; bif.a = a[7:0]; bif.b = b[7:0]; bif.cin = ci; bif.sub = su; end
    endcase
  endtask

  task automatic set_ready(input int w, input logic r);
    case (w)
      0: dif.out_ready = r;
      1: sif.out_ready = r;
      2: aif.out_ready = r;
      default: bif.out_ready = r;
    endcase
  endtask

  task automatic peek(input int w, output logic ov, output logic [99:0] s,
                      output logic co, output logic ir);
    case (w)
      0: begin ov = dif.out_valid; s = dif.sum; co = dif.cout; ir = dif.in_ready; end
      1: begin ov = sif.out_valid; s = sif.sum; co = sif.cout; ir = sif.in_ready; end
      2: begin ov = aif.out_valid; s = {92'd0, aif.sum}; co = aif.cout; ir = aif.in_ready; end
      default: begin ov = bif.out_valid; s = {92'd0, bif.sum}; co = bif.cout; ir = bif.in_ready; end
    endcase
  endtask

  // Offers one beat at the current falling edge, then waits for the result.
  // lat counts rising edges from the capture edge, inclusive. It is -1 when
  // no result appeared within the budget.
  task automatic beat(input int w, input logic [99:0] a, input logic [99:0] b,
                      input logic ci, input logic su,
                      output logic [99:0] s, output logic co, output int lat);
    logic ov, ir;
    drive(w, 1'b1, a, b, ci, su);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drive(w, 1'b0, '0, '0, 1'b0, 1'b0);
    peek(w, ov, s, co, ir);
    while (!ov && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      peek(w, ov, s, co, ir);
    end
    if (!ov) lat = -1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic ov, co, ir;
    logic [99:0] s;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      peek(w, ov, s, co, ir);
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", w, ov); end
      n_cmp++; if (s !== 100'd0) begin n_bad++; $display("FAIL reset_sum[%0d]: got %h want 0", w, s); end
      n_cmp++; if (co !== 1'b0) begin n_bad++; $display("FAIL reset_cout[%0d]: got %b want 0", w, co); end
      n_cmp++; if (ir !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", w, ir); end
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [99:0] ones, va[2], vb[2], es[2], s;
    logic vc[2], ec[2], co;
    int lat;
    ones = '1;
    va[0] = ones;   vb[0] = 100'd1; vc[0] = 1'b0; es[0] = 100'd0; ec[0] = 1'b1;
    va[1] = 100'd5; vb[1] = 100'd3; vc[1] = 1'b1; es[1] = 100'd9; ec[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      beat(0, va[i], vb[i], vc[i], 1'b0, s, co, lat);
      n_cmp++; if (s !== es[i]) begin n_bad++; $display("FAIL add_sum[%0d]: got %h want %h", i, s, es[i]); end
      n_cmp++; if (co !== ec[i]) begin n_bad++; $display("FAIL add_cout[%0d]: got %b want %b", i, co, ec[i]); end
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL add_latency[%0d]: got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_subtract();
    logic [99:0] ones, va[2], vb[2], es[2], s;
    logic ec[2], co;
    int lat;
    ones = '1;
    va[0] = 100'd10; vb[0] = 100'd3;  es[0] = 100'd7;          ec[0] = 1'b1;
    va[1] = 100'd3;  vb[1] = 100'd10; es[1] = ones - 100'd6;   ec[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      beat(0, va[i], vb[i], 1'b1, 1'b1, s, co, lat);
      n_cmp++; if (s !== es[i]) begin n_bad++; $display("FAIL sub_diff[%0d]: got %h want %h", i, s, es[i]); end
      n_cmp++; if (co !== ec[i]) begin n_bad++; $display("FAIL sub_cout[%0d]: got %b want %b", i, co, ec[i]); end
    end
  endtask

  task automatic test_cross_segment();
    logic [99:0] ones, va[2], vb[2], es[2], s;
    logic vc[2], ec[2], co;
    int lat;
    ones = '1;
    va[0] = {4'h0, {96{1'b1}}}; vb[0] = 100'd1; vc[0] = 1'b0; es[0] = {4'h1, 96'd0}; ec[0] = 1'b0;
    va[1] = ones;               vb[1] = ones;   vc[1] = 1'b1; es[1] = ones;          ec[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      beat(1, va[i], vb[i], vc[i], 1'b0, s, co, lat);
      n_cmp++; if (s !== es[i]) begin n_bad++; $display("FAIL seg32_sum[%0d]: got %h want %h", i, s, es[i]); end
      n_cmp++; if (co !== ec[i]) begin n_bad++; $display("FAIL seg32_cout[%0d]: got %b want %b", i, co, ec[i]); end
      n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL seg32_latency[%0d]: got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_degenerate();
    logic [99:0] s;
    logic co;
    int lat;
    int want_lat[4];
    want_lat[2] = 1;
    want_lat[3] = 8;
    for (int w = 2; w < 4; w++) begin
      beat(w, 100'd200, 100'd100, 1'b0, 1'b0, s, co, lat);
      n_cmp++; if (s !== 100'd44) begin n_bad++; $display("FAIL w8_sum[%0d]: got %0d want 44", w, s); end
      n_cmp++; if (co !== 1'b1) begin n_bad++; $display("FAIL w8_cout[%0d]: got %b want 1", w, co); end
      n_cmp++; if (lat != want_lat[w]) begin n_bad++; $display("FAIL w8_latency[%0d]: got %0d want %0d", w, lat, want_lat[w]); end
    end
  endtask

  // 20 random beats offered back to back while out_ready toggles at random.
  // The scoreboard records a beat when it is accepted and retires the oldest
  // entry when a result transfers.
  task automatic test_back_to_back(input int w);
    logic [100:0] q[$];
    logic [100:0] exp;
    logic [127:0] r;
    logic [99:0]  ra, rb, s, s_prev;
    logic         rc, rs, ov, co, ir, ordy, held, co_prev;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; held = 1'b0; s_prev = '0; co_prev = 1'b0;
    while (got < 20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      peek(w, ov, s, co, ir);
      if (held) begin
        n_cmp++;
        if (ov !== 1'b1 || s !== s_prev || co !== co_prev) begin
          n_bad++;
          $display("FAIL stall_hold[%0d]: got v=%b %b/%h want v=1 %b/%h", w, ov, co, s, co_prev, s_prev);
        end
      end
      r  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ra = r[99:0];
      r  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = r[99:0];
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      set_ready(w, ordy);
      drive(w, sent < 20, ra, rb, rc, rs);
      #1;
      peek(w, ov, s, co, ir);
      n_cmp++;
      if (ir !== !(ov && !ordy)) begin
        n_bad++;
        $display("FAIL in_ready[%0d]: got %b want %b", w, ir, !(ov && !ordy));
      end
      if (ov && ordy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra[%0d]: got %b/%h want none", w, co, s);
        end else begin
          exp = q.pop_front();
          if ({co, s} !== exp) begin
            n_bad++;
            $display("FAIL stream_data[%0d] beat %0d: got %b/%h want %b/%h", w, got, co, s, exp[100], exp[99:0]);
          end
        end
        got++;
      end
      if (sent < 20 && ir) begin
        q.push_back(ref_add(ra, rb, rc, rs));
        sent++;
      end
      held = ov && !ordy;
      s_prev = s;
      co_prev = co;
    end
    @(negedge clk);
    set_ready(w, 1'b1);
    drive(w, 1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++; if (got != 20) begin n_bad++; $display("FAIL stream_count[%0d]: got %0d want 20", w, got); end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL stream_leftover[%0d]: got %0d want 0", w, q.size()); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      peek(w, ov, s, co, ir);
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL stream_dup[%0d]: got out_valid %b want 0", w, ov); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [99:0] s;
    logic ov, co, ir;
    int lat, seen;
    set_ready(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 100'd1000 + 100'(i), 100'd7, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    peek(0, ov, s, co, ir);
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", ov); end
    n_cmp++; if (s !== 100'd0) begin n_bad++; $display("FAIL midrst_sum: got %h want 0", s); end
    n_cmp++; if (co !== 1'b0) begin n_bad++; $display("FAIL midrst_cout: got %b want 0", co); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      peek(0, ov, s, co, ir);
      if (ov === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_ghost: got %0d beats want 0", seen); end
    beat(0, 100'd123, 100'd456, 1'b0, 1'b0, s, co, lat);
    n_cmp++; if (s !== 100'd579) begin n_bad++; $display("FAIL midrst_new_sum: got %0d want 579", s); end
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL midrst_new_latency: got %0d want 4", lat); end
  endtask

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 4; w++) begin
      drive(w, 1'b0, '0, '0, 1'b0, 1'b0);
      set_ready(w, 1'b1);
    end
    test_reset();
    test_add();
    test_subtract();
    test_cross_segment();
    test_degenerate();
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
